shacc_pipe: RTL and testbench
=============================

SHACC_PIPE -- requirements
Module: shacc_pipe

Interface
REQ-001 SHALL have parameter BDIN, default 16: width of signed partial-product input from the bit-serial MVP array.
REQ-002 SHALL have parameter BACC, default 32: width of signed accumulator and output, BACC > BDIN.
REQ-003 SHALL have parameter SATURATE, default 1: 1 = clamp on overflow, 0 = two's-complement wrap.
REQ-004 SHALL have port clk, input, 1: single clock, all state rising-edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port clr, input, 1: synchronous clear, flushes all state.
REQ-007 SHALL have port in_valid, input, 1: data_in/sh/done/neg qualify this cycle.
REQ-008 SHALL have port data_in, input, BDIN: signed partial product for one bit-plane pair.
REQ-009 SHALL have port sh, input, 1: shift step from the address unit; accumulator doubles before adding.
REQ-010 SHALL have port neg, input, 1: subtract instead of add (exactly one operand on its MSB plane, signed mode).
REQ-011 SHALL have port done, input, 1: shacc_done from the address unit; this input closes the dot product.
REQ-012 SHALL have port acc_out, output, BACC: completed signed result.
REQ-013 SHALL have port out_valid, output, 1: one-cycle pulse, acc_out valid.
REQ-014 SHALL have port ovf, output, 1: overflow/saturation occurred in the result on acc_out; valid with out_valid.

Function
REQ-015 SHALL register in_valid, data_in, sh, neg, done in input stage S1 (1 cycle).
REQ-016 SHALL, in stage S2 when S1 valid, compute next = (sh ? acc*2 : acc) + (neg ? -sext(data_in) : sext(data_in)), sext to BACC+2 bits.
REQ-017 SHALL, if next exceeds BACC signed range: SATURATE=1 clamp to 2^(BACC-1)-1 or -2^(BACC-1); SATURATE=0 keep low BACC bits; either case set sticky ovf_acc.
REQ-018 SHALL treat doubling overflow identically to addition overflow (checked on the wide intermediate).
REQ-019 SHALL, when S1 valid and done, load acc_out <= clamped/wrapped next, ovf <= ovf_acc|this-cycle overflow, pulse out_valid next cycle, and reset acc and ovf_acc to 0 in the same edge.
REQ-020 SHALL give latency exactly 2 cycles: input sampled with done at edge N -> out_valid high in cycle after edge N+2.
REQ-021 SHALL accept one input per cycle, no stall; back-to-back done inputs SHALL each produce a result.
REQ-022 SHALL hold acc_out and ovf stable between out_valid pulses.
REQ-023 SHALL ignore sh, neg, done, data_in when in_valid is 0 (no state change).
REQ-024 SHALL let clr override everything in the same cycle: S1 valid, acc, ovf_acc, out_valid to 0; a done sampled with clr is dropped.
REQ-025 SHALL apply sh to acc=0 after a done without effect (first plane after result).
REQ-026 SHALL handle data_in = -2^(BDIN-1) with neg=1 correctly (+2^(BDIN-1), no truncation).

Reset
REQ-027 SHALL, on rst_n low, asynchronously set acc, ovf_acc, S1 registers, acc_out, ovf, out_valid to 0.
REQ-028 SHALL, after rst_n rises, accept input on the first clock edge.
REQ-029 SHALL discard any in-flight partial sum on reset mid-operation; no out_valid from it.

Structure
REQ-030 SHALL take BDIN/BACC defaults from the shared mvu package alongside BPREC/BDBANKA/BWBANKA constants.
REQ-031 SHALL place the widen/shift/add/clamp datapath in one sub-module shacc_satadd (combinational, parameterised BDIN, BACC, SATURATE).

Verification
REQ-032 SHALL check 2x2-bit unsigned: inputs (3,sh0),(5,sh1),(2,sh0),(7,sh1,done) -> acc_out=((3*2+5+2)*2+7)=33, out_valid 2 cycles after done.
REQ-033 SHALL check signed: (4,neg1),(6,sh1,neg0,done) -> acc_out=-2, ovf=0.
REQ-034 SHALL check BACC=8, SATURATE=1: acc=100, input (50,sh1,done) -> acc_out=127, ovf=1; SATURATE=0 -> acc_out=-6 (250 wrapped), ovf=1.
REQ-035 SHALL check back-to-back: done on consecutive valid inputs 9 then 11 -> two consecutive out_valid pulses, acc_out 9 then 11.
REQ-036 SHALL check clr coincident with done, and rst_n low mid-accumulation -> no out_valid, next result starts from 0.

Source files
------------

// File: rtl/mvu_pkg.sv
// Shared constants for the matrix-vector unit: operand precision, bank address
// widths, and the default widths of the shift-accumulate datapath.
package mvu_pkg;

    localparam int BPREC   = 16;  // maximum operand precision in bit-planes
    localparam int BDBANKA = 10;  // data bank address width
    localparam int BWBANKA = 12;  // weight bank address width

    localparam int BDIN = 16;     // partial product width from the bit-serial array
    localparam int BACC = 32;     // accumulator / result width

endpackage

// File: rtl/shacc_satadd.sv
// Combinational shift-accumulate step: optional doubling, signed add/subtract
// and overflow detection on a two-bit-wide intermediate, then clamp or wrap.
module shacc_satadd #(
    parameter int BDIN     = mvu_pkg::BDIN,
    parameter int BACC     = mvu_pkg::BACC,
    parameter int SATURATE = 1
) (
    input  logic [BACC-1:0] acc,
    input  logic [BDIN-1:0] data_in,
    input  logic            sh,
    input  logic            neg,
    output logic [BACC-1:0] sum,
    output logic            ovf
);

    localparam int BW = BACC + 2;

    logic [BW-1:0] acc_w;
    logic [BW-1:0] din_w;
    logic [BW-1:0] base;
    logic [BW-1:0] addend;
    logic [BW-1:0] next;

    // Two guard bits hold 2*acc + |data_in| exactly, including negating -2^(BDIN-1).
    always_comb begin
        acc_w  = {{2{acc[BACC-1]}}, acc};
        din_w  = {{(BW-BDIN){data_in[BDIN-1]}}, data_in};
        base   = sh  ? {acc_w[BW-2:0], 1'b0} : acc_w;
        addend = neg ? (~din_w + 1'b1) : din_w;
        next   = base + addend;
        ovf    = (next[BW-1:BACC-1] != {(BW-BACC+1){next[BW-1]}});
        if (ovf && (SATURATE != 0)) begin
            sum = next[BW-1] ? {1'b1, {(BACC-1){1'b0}}} : {1'b0, {(BACC-1){1'b1}}};
        end else begin
            sum = next[BACC-1:0];
        end
    end

endmodule

// File: rtl/shacc_pipe.sv
// Shift-accumulator for bit-serial dot products: input register, accumulate
// stage, and a result register that presents each finished sum with a pulse.
module shacc_pipe #(
    parameter int BDIN     = mvu_pkg::BDIN,
    parameter int BACC     = mvu_pkg::BACC,
    parameter int SATURATE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            in_valid,
    input  logic [BDIN-1:0] data_in,
    input  logic            sh,
    input  logic            neg,
    input  logic            done,
    output logic [BACC-1:0] acc_out,
    output logic            out_valid,
    output logic            ovf
);

    logic            s1_valid;
    logic [BDIN-1:0] s1_data;
    logic            s1_sh;
    logic            s1_neg;
    logic            s1_done;

    logic [BACC-1:0] acc;
    logic            ovf_acc;
    logic [BACC-1:0] sum;
    logic            ovf_now;

    logic            r_valid;
    logic [BACC-1:0] r_acc;
    logic            r_ovf;

    shacc_satadd #(
        .BDIN     (BDIN),
        .BACC     (BACC),
        .SATURATE (SATURATE)
    ) u_satadd (
        .acc     (acc),
        .data_in (s1_data),
        .sh      (s1_sh),
        .neg     (s1_neg),
        .sum     (sum),
        .ovf     (ovf_now)
    );

    // NOTE: every register here, including the datapath ones, is reset so no
    // X from a stale partial sum can reach acc_out; sequential state uses <= only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_sh    <= 1'b0;
            s1_neg   <= 1'b0;
            s1_done  <= 1'b0;
        end else if (clr) begin
            s1_valid <= 1'b0;
            s1_done  <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= data_in;
                s1_sh   <= sh;
                s1_neg  <= neg;
                s1_done <= done;
            end
        end
    end

    // A closing plane hands its sum to the result register and restarts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            ovf_acc <= 1'b0;
            r_valid <= 1'b0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else if (clr) begin
            acc     <= '0;
            ovf_acc <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= s1_valid && s1_done;
            if (s1_valid) begin
                if (s1_done) begin
                    r_acc   <= sum;
                    r_ovf   <= ovf_acc | ovf_now;
                    acc     <= '0;
                    ovf_acc <= 1'b0;
                end else begin
                    acc     <= sum;
                    ovf_acc <= ovf_acc | ovf_now;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            acc_out   <= '0;
            ovf       <= 1'b0;
        end else if (clr) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= r_valid;
            if (r_valid) begin
                acc_out <= r_acc;
                ovf     <= r_ovf;
            end
        end
    end

endmodule

// File: tb/tb_shacc_pipe.sv
// Scoreboard bench for shacc_pipe: one default instance and two 8-bit
// instances (saturating and wrapping) share the stimulus; each has its own model.
module tb_shacc_pipe;

    typedef struct {
        longint val;
        bit     ovf;
        int     cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [15:0] data_in;
    logic        sh;
    logic        neg;
    logic        done;

    logic [31:0] acc_out0;
    logic        out_valid0;
    logic        ovf0;
    logic [7:0]  acc_out1;
    logic        out_valid1;
    logic        ovf1;
    logic [7:0]  acc_out2;
    logic        out_valid2;
    logic        ovf2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    longint m_acc[3];
    bit     m_ovf[3];
    longint last_exp[3];
    int     pulses[3];
    int     pushed[3];

    const int bdin_k[3] = '{16, 7, 7};
    const int bacc_k[3] = '{32, 8, 8};
    const int sat_k[3]  = '{1, 1, 0};

    shacc_pipe u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .data_in(data_in),
        .sh(sh), .neg(neg), .done(done),
        .acc_out(acc_out0), .out_valid(out_valid0), .ovf(ovf0)
    );

    shacc_pipe #(.BDIN(7), .BACC(8), .SATURATE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .data_in(data_in[6:0]),
        .sh(sh), .neg(neg), .done(done),
        .acc_out(acc_out1), .out_valid(out_valid1), .ovf(ovf1)
    );

    shacc_pipe #(.BDIN(7), .BACC(8), .SATURATE(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .data_in(data_in[6:0]),
        .sh(sh), .neg(neg), .done(done),
        .acc_out(acc_out2), .out_valid(out_valid2), .ovf(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint dut_val(input int k);
        case (k)
            0:       return longint'($signed(acc_out0));
            1:       return longint'($signed(acc_out1));
            default: return longint'($signed(acc_out2));
        endcase
    endfunction

    function automatic longint dut_ovf(input int k);
        case (k)
            0:       return longint'(ovf0);
            1:       return longint'(ovf1);
            default: return longint'(ovf2);
        endcase
    endfunction

    function automatic logic dut_vld(input int k);
        case (k)
            0:       return out_valid0;
            1:       return out_valid1;
            default: return out_valid2;
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push_exp(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
        pushed[k]++;
    endtask

    task automatic pop_exp(input int k, output exp_t e);
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    // Reference model in plain integer arithmetic, one per instance width.
    task automatic model_step(input logic [15:0] d, input bit s, input bit n, input bit dn);
        for (int k = 0; k < 3; k++) begin
            longint b    = longint'(bacc_k[k]);
            longint hi   = (64'sd1 <<< (b - 1)) - 1;
            longint lo   = -(64'sd1 <<< (b - 1));
            longint dv   = longint'(d) & ((64'sd1 <<< bdin_k[k]) - 1);
            longint nxt;
            longint v;
            bit     o;
            exp_t   e;
            if (dv >= (64'sd1 <<< (bdin_k[k] - 1))) dv = dv - (64'sd1 <<< bdin_k[k]);
            nxt = (s ? 2 * m_acc[k] : m_acc[k]) + (n ? -dv : dv);
            o   = (nxt > hi) || (nxt < lo);
            if (!o) begin
                v = nxt;
            end else if (sat_k[k] != 0) begin
                v = (nxt > hi) ? hi : lo;
            end else begin
                v = nxt & ((64'sd1 <<< b) - 1);
                if (v > hi) v = v - (64'sd1 <<< b);
            end
            if (dn) begin
                e.val = v;
                e.ovf = m_ovf[k] | o;
                e.cyc = cyc + 3;
                push_exp(k, e);
                m_acc[k] = 0;
                m_ovf[k] = 1'b0;
            end else begin
                m_acc[k] = v;
                m_ovf[k] = m_ovf[k] | o;
            end
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0;
            m_ovf[k] = 1'b0;
        end
    endtask

    task automatic send(input logic [15:0] d, input bit s, input bit n, input bit dn);
        in_valid = 1'b1;
        data_in  = d;
        sh       = s;
        neg      = n;
        done     = dn;
        model_step(d, s, n, dn);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Idle cycles carry random sideband values that must all be ignored.
    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            in_valid = 1'b0;
            data_in  = 16'($urandom);
            sh       = 1'($urandom);
            neg      = 1'($urandom);
            done     = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_clr_done(input logic [15:0] d);
        clr      = 1'b1;
        in_valid = 1'b1;
        data_in  = d;
        sh       = 1'b0;
        neg      = 1'b0;
        done     = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 3; k++) begin
            check("reset_acc_out", dut_val(k), 0);
            check("reset_ovf", dut_ovf(k), 0);
            check("reset_out_valid", longint'(dut_vld(k)), 0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (dut_vld(k)) begin
                    pulses[k]++;
                    if (qsize(k) == 0) begin
                        check("unexpected_out_valid", 1, 0);
                    end else begin
                        exp_t e;
                        pop_exp(k, e);
                        check("acc_out", dut_val(k), e.val);
                        check("ovf", dut_ovf(k), longint'(e.ovf));
                        check("latency_cycle", longint'(cyc), longint'(e.cyc));
                        last_exp[k] = e.val;
                    end
                end else begin
                    check("acc_out_hold", dut_val(k), last_exp[k]);
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        sh       = 1'b0;
        neg      = 1'b0;
        done     = 1'b0;
        model_clear();
        for (int k = 0; k < 3; k++) begin
            last_exp[k] = 0;
            pulses[k]   = 0;
            pushed[k]   = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        // Unsigned 2x2-bit planes: ((3*2+5+2)*2+7) = 33, accepted on the first edge.
        send(16'd3, 0, 0, 0);
        send(16'd5, 1, 0, 0);
        send(16'd2, 0, 0, 0);
        send(16'd7, 1, 0, 1);
        idle(2);

        // Signed: -4 then doubled plus 6 = -2.
        send(16'd4, 0, 1, 0);
        send(16'd6, 1, 0, 1);
        idle(1);

        // Most negative partial product negated.
        send(16'h8000, 0, 1, 1);

        // 100 then doubled plus 50: 250 on the wide unit, clamp/wrap on the 8-bit ones.
        send(16'd50, 0, 0, 0);
        send(16'd50, 0, 0, 0);
        send(16'd50, 1, 0, 1);

        // Back-to-back results, then a shift straight after a result.
        send(16'd9, 0, 0, 1);
        send(16'd11, 0, 0, 1);
        send(16'd5, 1, 0, 1);
        idle(4);

        // Clear coincident with done drops the result; the next one starts from zero.
        send(16'd20, 0, 0, 0);
        idle(1);
        send_clr_done(16'd7);
        idle(4);
        send(16'd3, 0, 0, 1);
        idle(4);

        // Reset mid-accumulation with a partial sum still in the input stage.
        send(16'd40, 0, 0, 0);
        send(16'd30, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        model_clear();
        for (int k = 0; k < 3; k++) last_exp[k] = 0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(16'd6, 0, 0, 1);
        idle(2);

        for (int i = 0; i < 40; i++) begin
            send(16'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        send(16'd1, 1, 0, 1);

        for (int i = 0; i < 30 && (q0.size() + q1.size() + q2.size()) != 0; i++) begin
            @(posedge clk);
        end
        #1;
        check("drain_pending", longint'(q0.size() + q1.size() + q2.size()), 0);
        idle(3);
        for (int k = 0; k < 3; k++) begin
            check("pulse_count", longint'(pulses[k]), longint'(pushed[k]));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
